// File: rtl/load_store_unit_if.sv
// Data-cache request/response bus between the load/store unit (master) and the data cache (slave).
interface load_store_unit_if;
   logic        mem_request;
   logic        mem_re;
   logic        mem_we;
   logic        mem_load;
   logic [3:0]  mem_mask;
   logic [7:0]  mem_address;
   logic [31:0] mem_wdata;
   logic        mem_valid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_request, mem_re, mem_we, mem_load, mem_mask, mem_address, mem_wdata,
      input  mem_valid, mem_rdata
   );

   modport slave (
      input  mem_request, mem_re, mem_we, mem_load, mem_mask, mem_address, mem_wdata,
      output mem_valid, mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding data-cache access, lane steering, load extension, error reporting.
// Optional feature macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing alignment.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     op_valid,
   input  logic                     op_is_store,
   input  logic [2:0]               op_funct3,
   input  logic [31:0]              op_addr,
   input  logic [31:0]              op_wdata,
   output logic                     op_ready,
   output logic                     busy,
   output logic                     res_valid,
   output logic [31:0]              res_data,
   output logic                     exc_valid,
   output logic [1:0]               exc_cause,
   load_store_unit_if.master        mem
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;
   localparam logic [7:0] TMO_LAST       = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic        store_q;
   logic [7:0]  tmo_cnt;

   logic [1:0]  size;
   logic        legal;
   logic [1:0]  eff_off;
   logic [3:0]  dec_mask;
   logic [31:0] dec_wdata;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_ext;

   // Only the low ten address bits reach the cache.
   logic        unused_addr_hi;
   assign unused_addr_hi = ^op_addr[31:10];

   assign size = op_funct3[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((size == 2'b01) && op_addr[0]) ||
                       ((size == 2'b10) && (op_addr[1:0] != 2'b00));
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      legal     = 1'b0;
      eff_off   = op_addr[1:0];
      dec_mask  = 4'b0000;
      dec_wdata = 32'h0;
      case (op_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !op_is_store;
         default:                legal = 1'b0;
      endcase
`ifndef LSU_MISALIGN_TRAP_EN
      // Misaligned halfword/word accesses are silently rounded down to their natural boundary.
      case (size)
         2'b01:   eff_off = {op_addr[1], 1'b0};
         2'b10:   eff_off = 2'b00;
         default: eff_off = op_addr[1:0];
      endcase
`endif
      if (op_is_store) begin
         case (size)
            2'b00: begin
               dec_mask  = 4'b0001 << eff_off;
               dec_wdata = {4{op_wdata[7:0]}};
            end
            2'b01: begin
               dec_mask  = eff_off[1] ? 4'b1100 : 4'b0011;
               dec_wdata = {2{op_wdata[15:0]}};
            end
            default: begin
               dec_mask  = 4'b1111;
               dec_wdata = op_wdata;
            end
         endcase
      end
   end

   always_comb begin
      lane_b = mem.mem_rdata[{off_q, 3'b000} +: 8];
      lane_h = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      case (funct3_q)
         3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_ext = {24'h0, lane_b};
         3'b101:  load_ext = {16'h0, lane_h};
         default: load_ext = mem.mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         op_ready        <= 1'b1;
         busy            <= 1'b0;
         res_valid       <= 1'b0;
         res_data        <= 32'h0;
         exc_valid       <= 1'b0;
         exc_cause       <= 2'b00;
         mem.mem_request <= 1'b0;
         mem.mem_re      <= 1'b0;
         mem.mem_we      <= 1'b0;
         mem.mem_load    <= 1'b0;
         mem.mem_mask    <= 4'b0000;
         mem.mem_address <= 8'h00;
         mem.mem_wdata   <= 32'h0;
         funct3_q        <= 3'b000;
         off_q           <= 2'b00;
         store_q         <= 1'b0;
         tmo_cnt         <= 8'h00;
      end else begin
         // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
         res_valid <= 1'b0;
         exc_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (op_valid) begin
                  if (!legal) begin
                     exc_valid <= 1'b1;
                     exc_cause <= CAUSE_ILLEGAL;
`ifdef LSU_MISALIGN_TRAP_EN
                  end else if (misaligned) begin
                     exc_valid <= 1'b1;
                     exc_cause <= CAUSE_MISALIGN;
`endif
                  end else begin
                     funct3_q        <= op_funct3;
                     off_q           <= eff_off;
                     store_q         <= op_is_store;
                     mem.mem_address <= op_addr[9:2];
                     mem.mem_mask    <= dec_mask;
                     mem.mem_wdata   <= dec_wdata;
                     mem.mem_re      <= !op_is_store;
                     mem.mem_load    <= !op_is_store;
                     mem.mem_we      <= op_is_store;
                     mem.mem_request <= 1'b1;
                     tmo_cnt         <= 8'h00;
                     op_ready        <= 1'b0;
                     busy            <= 1'b1;
                     state           <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // A response on the terminal-count cycle still completes the access.
               if (mem.mem_valid) begin
                  res_valid       <= 1'b1;
                  res_data        <= store_q ? 32'h0 : load_ext;
                  mem.mem_request <= 1'b0;
                  mem.mem_re      <= 1'b0;
                  mem.mem_load    <= 1'b0;
                  mem.mem_we      <= 1'b0;
                  state           <= S_RESP;
               end else if (tmo_cnt == TMO_LAST) begin
                  exc_valid       <= 1'b1;
                  exc_cause       <= CAUSE_TIMEOUT;
                  mem.mem_request <= 1'b0;
                  mem.mem_re      <= 1'b0;
                  mem.mem_load    <= 1'b0;
                  mem.mem_we      <= 1'b0;
                  state           <= S_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'h01;
               end
            end
            S_RESP: begin
               // Swallows the response the cache re-issues to the request seen still high.
               op_ready <= 1'b1;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               op_ready <= 1'b1;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
